// File: rtl/fetch_prefetch_pkg.sv
// fetch_pkg: shared defaults and helpers for the fetch_prefetch unit.
//   DEF_DATA_W / DEF_ADDR_W / DEF_DEPTH / DEF_RESET_PC : default parameters
//   INSTR_BYTES   : PC increment for the default instruction width
//   cnt_w()       : width of a counter that must hold 0..depth inclusive
//   fetch_entry_t : {instr, pc} pair held in the instruction buffer
// Optional feature macro used by the unit: FETCH_BYPASS_EN.
package fetch_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_ADDR_W   = 16;
    localparam int unsigned DEF_DEPTH    = 4;
    localparam int unsigned DEF_RESET_PC = 0;
    localparam int unsigned INSTR_BYTES  = DEF_DATA_W / 8;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// fetch_fifo: synchronous FIFO with occupancy count and synchronous flush.
//   clk, rst (async, active-high), flush (empties the FIFO this edge)
//   push / push_data : write when not full (or when popping while full)
//   pop  / pop_data  : pop_data shows the head entry combinationally
//   count            : number of valid entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && (count != '0);
    // A pop frees the head slot in the same edge, so push-on-full is safe then.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: pipelined instruction-fetch unit.
//   halt                 : stop issuing fetches, keep delivering buffered ones
//   redirect/redirect_pc : flush and restart fetching at redirect_pc
//   imem_req/addr/gnt    : request side of the instruction memory
//   imem_rvalid/rdata    : in-order responses
//   instr_valid/ready    : handshake to decode with instr, instr_pc, nxt_pc
// Up to DEPTH fetches may be outstanding or buffered at once.
// Define FETCH_BYPASS_EN to forward a response straight to decode in the
// cycle it arrives when nothing is buffered; otherwise decode sees only
// buffered instructions (earliest one cycle after the response).
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       DEPTH    = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] nxt_pc
);

    localparam int unsigned CW   = cnt_w(DEPTH);
    localparam int unsigned STEP = DATA_W / 8;
    localparam int unsigned EW   = DATA_W + ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     pc_count;
    logic [CW-1:0]     ib_count;
    logic [ADDR_W-1:0] issued_pc;
    logic [EW-1:0]     ib_head_raw;
    entry_t            ib_head;
    entry_t            rsp_entry;
    entry_t            out_entry;
    logic              out_avail;
    logic              gnt_fire;
    logic              rv_eff;
    logic              accept_rsp;
    logic              ib_empty;
    logic              ib_push;
    logic              ib_pop;

    // Responses with nothing outstanding are a protocol error and are ignored.
    assign rv_eff     = imem_rvalid && (inflight != '0);
    assign accept_rsp = rv_eff && (drop_cnt == '0);
    assign gnt_fire   = imem_req && imem_gnt;
    assign ib_empty   = (ib_count == '0);
    assign ib_head    = ib_head_raw;
    assign rsp_entry  = '{instr: imem_rdata, pc: issued_pc};

    // Credit: outstanding plus buffered never exceeds DEPTH, so the
    // instruction buffer can always absorb every response in flight.
    assign imem_req  = !rst && !halt && !redirect &&
                       (({1'b0, inflight} + {1'b0, ib_count}) < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass    = ib_empty && accept_rsp;
    assign out_avail = !ib_empty || bypass;
    assign out_entry = ib_empty ? rsp_entry : ib_head;
    assign ib_push   = accept_rsp && !redirect && !(bypass && instr_ready);
`else
    assign out_avail = !ib_empty;
    assign out_entry = ib_head;
    assign ib_push   = accept_rsp && !redirect;
`endif

    assign instr_valid = out_avail && !redirect;
    assign ib_pop      = instr_valid && instr_ready && !ib_empty;
    assign instr       = instr_valid ? out_entry.instr : '0;
    assign instr_pc    = instr_valid ? out_entry.pc : '0;
    assign nxt_pc      = instr_valid ? out_entry.pc + ADDR_W'(STEP) : '0;

    // Issued PCs are never flushed: entries for responses still owed after a
    // redirect are popped as those (discarded) responses arrive.
    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (gnt_fire),
        .push_data (fetch_pc),
        .pop       (rv_eff),
        .pop_data  (issued_pc),
        .count     (pc_count)
    );

    fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (ib_push),
        .push_data (rsp_entry),
        .pop       (ib_pop),
        .pop_data  (ib_head_raw),
        .count     (ib_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(gnt_fire) - CW'(rv_eff);
            if (redirect) begin
                fetch_pc <= redirect_pc;
                drop_cnt <= inflight - CW'(rv_eff);
            end else begin
                if (gnt_fire) fetch_pc <= fetch_pc + ADDR_W'(STEP);
                if (rv_eff && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    rvalid_needs_credit: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (inflight != '0));

    pc_fifo_tracks_inflight: assert property (@(posedge clk) disable iff (rst)
        pc_count == inflight);

endmodule

// File: tb/tb_fetch_prefetch.sv
module tb_fetch_prefetch;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [AW-1:0] pc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          halt;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic [AW-1:0] nxt_pc;

    int total = 0;
    int bad   = 0;
    int gnt_cnt = 0;
    int deliv_cnt = 0;
    logic [AW-1:0] last_gnt = '0;
    logic [AW-1:0] held;
    logic mem_hold = 1'b0;
    logic stale_en = 1'b0;

    exp_t          sb_q[$];
    logic [AW-1:0] pend_q[$];
    logic [AW-1:0] got_pc[$];
    logic [AW-1:0] got_nxt[$];

`ifdef FETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    fetch_prefetch #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .nxt_pc      (nxt_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 16'h3C5A;
    endfunction

    function automatic logic [AW-1:0] got_at(input int i);
        if (i < got_pc.size()) return got_pc[i];
        return 'x;
    endfunction

    function automatic logic [AW-1:0] nxt_at(input int i);
        if (i < got_nxt.size()) return got_nxt[i];
        return 'x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic quiesce();
        halt = 1'b1;
        instr_ready = 1'b1;
        mem_hold = 1'b0;
        repeat (6) step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    // Instruction memory: accepts every request while gnt is high and
    // answers in order one cycle later unless held back.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst && stale_en) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 16'hDEAD;
            end else if (!rst && !mem_hold && pend_q.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_q.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    end

    // Grant observer: each accepted request is stimulus whose expected
    // decode-side result goes into the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_q.delete();
            end else if (imem_req && imem_gnt) begin
                pend_q.push_back(imem_addr);
                sb_q.push_back('{instr: mem_word(imem_addr), pc: imem_addr});
                gnt_cnt++;
                last_gnt = imem_addr;
            end
        end
    end

    // Monitor: compares every instruction handed to decode against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (redirect) chk("redirect_valid_low", 32'(instr_valid), 32'd0);
            if (instr_valid && instr_ready) begin
                deliv_cnt++;
                got_pc.push_back(instr_pc);
                got_nxt.push_back(nxt_pc);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_instr: got pc %h instr %h expected none", instr_pc, instr);
                end else begin
                    e = sb_q.pop_front();
                    chk("instr", 32'(instr), 32'(e.instr));
                    chk("instr_pc", 32'(instr_pc), 32'(e.pc));
                    chk("nxt_pc", 32'(nxt_pc), 32'(16'(e.pc + 16'd2)));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b1; instr_ready = 1'b1;
        repeat (2) step();

        // reset state
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_nxt", 32'(nxt_pc), 32'd0);

        // first request and fetch-to-decode latency
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", 32'(imem_addr), 32'h0000);
        @(negedge clk);
        chk("rsp_cycle_valid", 32'(instr_valid), 32'(BYP));

        // sustained streaming
        repeat (4) step();
        deliv_cnt = 0;
        repeat (8) step();
        chk("throughput", 32'(deliv_cnt), 32'd8);
        chk("seq_pc0", 32'(got_at(0)), 32'h0000);
        chk("seq_pc1", 32'(got_at(1)), 32'h0002);
        chk("seq_pc2", 32'(got_at(2)), 32'h0004);
        chk("seq_nxt0", 32'(nxt_at(0)), 32'h0002);

        // halt with work in flight
        halt = 1'b1;
        held = last_gnt + 16'd2;
        deliv_cnt = 0;
        gnt_cnt = 0;
        repeat (6) step();
        chk("halt_gnts", 32'(gnt_cnt), 32'd0);
        chk("halt_deliv", 32'(deliv_cnt), 32'(2 - BYP));
        chk("halt_req", 32'(imem_req), 32'd0);
        chk("halt_addr_held", 32'(imem_addr), 32'(held));
        chk("halt_sb_empty", 32'(sb_q.size()), 32'd0);

        // resume with decode stalled: credit limit
        halt = 1'b0;
        instr_ready = 1'b0;
        gnt_cnt = 0;
        deliv_cnt = 0;
        @(negedge clk);
        chk("resume_addr", 32'(imem_addr), 32'(held));
        step();
        repeat (9) step();
        chk("stall_gnts", 32'(gnt_cnt), 32'd4);
        chk("stall_req_low", 32'(imem_req), 32'd0);
        chk("stall_deliv", 32'(deliv_cnt), 32'd0);
        got_pc.delete();
        got_nxt.delete();
        instr_ready = 1'b1;
        repeat (8) step();
        chk("stall_first", 32'(got_at(0)), 32'(held));
        chk("stall_fourth", 32'(got_at(3)), 32'(16'(held + 16'd6)));
        quiesce();

        // redirect with three in flight and a same-cycle response
        halt = 1'b0;
        mem_hold = 1'b1;
        gnt_cnt = 0;
        repeat (3) step();
        halt = 1'b1;
        mem_hold = 1'b0;
        chk("pre_redirect_gnts", 32'(gnt_cnt), 32'd3);
        step();
        chk("redirect_rsp_same_cycle", 32'(imem_rvalid), 32'd1);
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        halt = 1'b0;
        sb_q.delete();
        got_pc.delete();
        got_nxt.delete();
        #1;
        chk("redirect_req_low", 32'(imem_req), 32'd0);
        step();
        redirect = 1'b0;
        repeat (7) step();
        chk("redirect_first", 32'(got_at(0)), 32'h0100);
        chk("redirect_second", 32'(got_at(1)), 32'h0102);
        quiesce();

        // address wrap
        redirect = 1'b1;
        redirect_pc = 16'hFFFC;
        halt = 1'b0;
        got_pc.delete();
        got_nxt.delete();
        step();
        redirect = 1'b0;
        repeat (8) step();
        chk("wrap_pc0", 32'(got_at(0)), 32'hFFFC);
        chk("wrap_pc1", 32'(got_at(1)), 32'hFFFE);
        chk("wrap_nxt1", 32'(nxt_at(1)), 32'h0000);
        chk("wrap_pc2", 32'(got_at(2)), 32'h0000);
        quiesce();

        // reset mid-stream with three in flight
        halt = 1'b0;
        instr_ready = 1'b0;
        step();
        mem_hold = 1'b1;
        repeat (4) step();
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        rst = 1'b1;
        stale_en = 1'b1;
        sb_q.delete();
        #1;
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr", 32'(instr), 32'd0);
        chk("mid_rst_pc", 32'(instr_pc), 32'd0);
        chk("mid_rst_nxt", 32'(nxt_pc), 32'd0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        step();
        stale_en = 1'b0;
        step();
        rst = 1'b0;
        mem_hold = 1'b0;
        instr_ready = 1'b1;
        got_pc.delete();
        got_nxt.delete();
        @(negedge clk);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_addr", 32'(imem_addr), 32'h0000);
        repeat (6) step();
        chk("post_rst_first", 32'(got_at(0)), 32'h0000);
        chk("post_rst_second", 32'(got_at(1)), 32'h0002);
        quiesce();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
